// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode codes, response status codes and dispatcher state encoding
package mode_pkg;

  localparam int N_MODES = 5;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_STORE = 3'd1;
  localparam logic [2:0] MODE_GEN   = 3'd2;
  localparam logic [2:0] MODE_SHOW  = 3'd3;
  localparam logic [2:0] MODE_CALC  = 3'd4;
  localparam logic [2:0] MODE_SETUP = 3'd5;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERROR   = 2'b01,
    ST_ABORTED = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_ABORT    = 3'd2,
    S_RESP     = 3'd3,
    S_ERR_HOLD = 3'd4
  } disp_state_t;

  function automatic logic is_valid_mode(input logic [2:0] code);
    return (code >= MODE_STORE) && (code <= MODE_SETUP);
  endfunction

  function automatic logic [N_MODES-1:0] mode_to_onehot(input logic [2:0] code);
    logic [N_MODES-1:0] oh;
    oh = '0;
    if (is_valid_mode(code)) oh = N_MODES'(1) << (code - 3'd1);
    return oh;
  endfunction

endpackage

// File: rtl/err_blinker.sv
// rtl/err_blinker.sv - error-window timer: toggles led every period cycles, flags done after window cycles
module err_blinker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_period,
  input  logic [31:0] i_window,
  output logic        o_led,
  output logic        o_done
);

  logic [31:0] r_win_cnt;
  logic [31:0] r_per_cnt;
  logic        r_led;
  logic        w_per_end;

  assign w_per_end = (r_per_cnt + 32'd1) >= i_period;
  assign o_done    = i_enable && ((r_win_cnt + 32'd1) >= i_window);
  assign o_led     = r_led;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt <= '0;
      r_per_cnt <= '0;
      r_led     <= 1'b0;
    end else if (!i_enable || o_done) begin
      r_win_cnt <= '0;
      r_per_cnt <= '0;
      r_led     <= 1'b0;
    end else begin
      r_win_cnt <= r_win_cnt + 32'd1;
      if (w_per_end) begin
        r_per_cnt <= '0;
        r_led     <= ~r_led;
      end else begin
        r_per_cnt <= r_per_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/mode_dispatcher.sv
// rtl/mode_dispatcher.sv - launches the requested subsystem, supervises it and returns a one-cycle completion response
module mode_dispatcher
  import mode_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TIMEOUT_S   = 30,
  parameter int unsigned ABORT_WAIT  = 1024,
  parameter int unsigned BLINK_HZ    = 4,
  parameter int unsigned ERR_HOLD_S  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       exit_pulse,
  output logic [4:0] sub_start,
  output logic [4:0] sub_abort,
  input  logic [4:0] sub_done,
  input  logic [4:0] sub_err,
  output logic [2:0] active_mode,
  output logic       resp_valid,
  output logic [1:0] resp_status,
  output logic       err_led
);

  localparam logic [31:0] WD_LIMIT     = 32'(CLK_FREQ_HZ * TIMEOUT_S);
  localparam logic [31:0] ABORT_LIMIT  = 32'(ABORT_WAIT);
  localparam logic [31:0] BLINK_PERIOD = 32'(CLK_FREQ_HZ / (2 * BLINK_HZ));
  localparam logic [31:0] HOLD_CYCLES  = 32'(CLK_FREQ_HZ * ERR_HOLD_S);
  localparam logic        WD_ENABLED   = (TIMEOUT_S != 0);

  disp_state_t r_state, w_next;
  status_t     r_status, w_next_status;
  logic [2:0]  r_code;
  logic [31:0] r_cnt;

  logic        r_req_ready, r_resp_valid;
  logic [4:0]  r_sub_start, r_sub_abort;
  logic [2:0]  r_active_mode;
  logic [1:0]  r_resp_status;

  logic        w_accept, w_done_sel, w_err_sel, w_wd_hit, w_abort_to, w_hold_done;
  logic [4:0]  w_sel;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_sel      = mode_to_onehot(r_code);
  assign w_done_sel = |(sub_done & w_sel);
  assign w_err_sel  = |(sub_err & w_sel);
  assign w_wd_hit   = WD_ENABLED && (r_cnt == WD_LIMIT - 32'd1);
  assign w_abort_to = (r_cnt + 32'd1) >= ABORT_LIMIT;

  // Completion from the subsystem outranks the user exit and the watchdog.
  always_comb begin
    w_next        = r_state;
    w_next_status = r_status;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (is_valid_mode(req_mode)) begin
            w_next = S_RUN;
          end else begin
            w_next        = S_RESP;
            w_next_status = ST_ERROR;
          end
        end
      end
      S_RUN: begin
        if (w_err_sel) begin
          w_next        = S_RESP;
          w_next_status = ST_ERROR;
        end else if (w_done_sel) begin
          w_next        = S_RESP;
          w_next_status = ST_OK;
        end else if (exit_pulse) begin
          w_next        = S_ABORT;
          w_next_status = ST_ABORTED;
        end else if (w_wd_hit) begin
          w_next        = S_ABORT;
          w_next_status = ST_TIMEOUT;
        end
      end
      S_ABORT: begin
        if (w_done_sel || w_err_sel || w_abort_to) w_next = S_RESP;
      end
      S_RESP: begin
        w_next = (r_status == ST_OK) ? S_IDLE : S_ERR_HOLD;
      end
      S_ERR_HOLD: begin
        if (w_hold_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_status <= ST_OK;
      r_code   <= MODE_NONE;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_status <= w_next_status;
      if (w_accept) r_code <= req_mode;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready   <= 1'b1;
      r_sub_start   <= '0;
      r_sub_abort   <= '0;
      r_active_mode <= MODE_NONE;
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
    end else begin
      r_req_ready   <= (w_next == S_IDLE);
      r_sub_start   <= w_accept ? mode_to_onehot(req_mode) : '0;
      r_sub_abort   <= (w_next == S_ABORT) ? w_sel : '0;
      r_active_mode <= (w_next == S_RUN || w_next == S_ABORT)
                       ? ((r_state == S_IDLE) ? req_mode : r_code) : MODE_NONE;
      r_resp_valid  <= (w_next == S_RESP);
      r_resp_status <= (w_next == S_RESP) ? w_next_status : ST_OK;
    end
  end

  err_blinker u_err_blinker (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (r_state == S_ERR_HOLD),
    .i_period (BLINK_PERIOD),
    .i_window (HOLD_CYCLES),
    .o_led    (err_led),
    .o_done   (w_hold_done)
  );

  assign req_ready   = r_req_ready;
  assign sub_start   = r_sub_start;
  assign sub_abort   = r_sub_abort;
  assign active_mode = r_active_mode;
  assign resp_valid  = r_resp_valid;
  assign resp_status = r_resp_status;

endmodule

// File: tb/tb_mode_dispatcher.sv
// tb/tb_mode_dispatcher.sv - directed and randomized checks of mode_dispatcher against a transaction-level model
module tb_mode_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic       req_ready;
  logic       exit_pulse = 1'b0;
  logic [4:0] sub_start, sub_abort;
  logic [4:0] sub_done = 5'd0;
  logic [4:0] sub_err = 5'd0;
  logic [2:0] active_mode;
  logic       resp_valid;
  logic [1:0] resp_status;
  logic       err_led;

  int total = 0;
  int bad = 0;

  mode_dispatcher #(
    .CLK_FREQ_HZ (100),
    .TIMEOUT_S   (2),
    .ABORT_WAIT  (8),
    .BLINK_HZ    (5),
    .ERR_HOLD_S  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_ready   (req_ready),
    .exit_pulse  (exit_pulse),
    .sub_start   (sub_start),
    .sub_abort   (sub_abort),
    .sub_done    (sub_done),
    .sub_err     (sub_err),
    .active_mode (active_mode),
    .resp_valid  (resp_valid),
    .resp_status (resp_status),
    .err_led     (err_led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = 1'b0;
    exit_pulse = 1'b0;
    sub_done   = 5'd0;
    sub_err    = 5'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic request(input logic [2:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input logic exp_led_seen);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (req_ready !== 1'b1 && n < 300) begin
      tick();
      if (err_led === 1'b1) seen = 1'b1;
      n++;
    end
    chk({tag, "_back_idle"}, 32'(n < 300), 32'd1);
    chk({tag, "_led_seen"}, 32'(seen), 32'(exp_led_seen));
  endtask

  // Expected response from the rules alone: invalid code or subsystem error -> ERROR,
  // completion (even together with exit) -> OK, user exit -> ABORTED.
  function automatic logic [1:0] model_status(input logic [2:0] m, input int sc);
    if (m < 3'd1 || m > 3'd5) return 2'b01;
    case (sc)
      0, 5:    return 2'b00;
      1, 6:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  initial begin
    logic [2:0] m;
    logic [4:0] exp_oh;
    logic [1:0] exp_st;
    int sc, d, da, w;

    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sub_start", sub_start, 0);
    chk("rst_sub_abort", sub_abort, 0);
    chk("rst_active", active_mode, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err_led", err_led, 0);
    rst_n = 1'b1;
    tick();

    // mode 3 runs to completion
    request(3'd3);
    chk("show_start", sub_start, 5'b00100);
    chk("show_active", active_mode, 3);
    chk("show_not_ready", req_ready, 0);
    tick();
    chk("show_start_pulse", sub_start, 0);
    sub_done = 5'b00100;
    tick();
    clear_inputs();
    chk("show_resp_valid", resp_valid, 1);
    chk("show_resp_ok", resp_status, 2'b00);
    chk("show_active_clr", active_mode, 0);
    tick();
    chk("show_idle", req_ready, 1);
    chk("show_resp_once", resp_valid, 0);
    chk("show_led", err_led, 0);

    // invalid code 6 -> ERROR then the blink window
    request(3'd6);
    chk("inv_no_start", sub_start, 0);
    chk("inv_resp_valid", resp_valid, 1);
    chk("inv_resp_err", resp_status, 2'b01);
    for (int i = 0; i < 100; i++) begin
      req_valid = (i == 50);
      req_mode  = 3'd2;
      tick();
      req_valid = 1'b0;
      chk("inv_blink", err_led, 32'((i / 10) % 2));
      chk("inv_not_ready", req_ready, 0);
      chk("inv_ignored_req", sub_start, 0);
    end
    tick();
    chk("inv_led_off", err_led, 0);
    chk("inv_ready", req_ready, 1);

    // mode 1, foreign done ignored, exit, forced completion after 8 cycles
    request(3'd1);
    chk("ab_start", sub_start, 5'b00001);
    sub_done = 5'b00010;
    tick();
    clear_inputs();
    chk("ab_foreign_done", {resp_valid, active_mode}, {1'b0, 3'd1});
    exit_pulse = 1'b1;
    tick();
    clear_inputs();
    chk("ab_abort", sub_abort, 5'b00001);
    repeat (7) tick();
    chk("ab_still_abort", {resp_valid, sub_abort}, {1'b0, 5'b00001});
    tick();
    chk("ab_resp_valid", resp_valid, 1);
    chk("ab_resp_status", resp_status, 2'b10);
    chk("ab_abort_clr", sub_abort, 0);
    wait_idle("ab", 1'b1);

    // mode 5 silent -> watchdog
    request(3'd5);
    repeat (199) tick();
    chk("wd_before", sub_abort, 0);
    tick();
    chk("wd_abort", sub_abort, 5'b10000);
    sub_done = 5'b10000;
    tick();
    clear_inputs();
    chk("wd_resp_valid", resp_valid, 1);
    chk("wd_resp_status", resp_status, 2'b11);
    wait_idle("wd", 1'b1);

    // done and exit in the same cycle -> OK
    request(3'd5);
    tick();
    sub_done   = 5'b10000;
    exit_pulse = 1'b1;
    tick();
    clear_inputs();
    chk("race_resp_valid", resp_valid, 1);
    chk("race_resp_ok", resp_status, 2'b00);
    chk("race_no_abort", sub_abort, 0);
    wait_idle("race", 1'b0);

    // asynchronous reset while aborting
    request(3'd2);
    exit_pulse = 1'b1;
    tick();
    clear_inputs();
    chk("rst_ab_abort", sub_abort, 5'b00010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ab_drop", sub_abort, 0);
    chk("rst_ab_ready", req_ready, 1);
    chk("rst_ab_active", active_mode, 0);
    #1 rst_n = 1'b1;
    tick();
    request(3'd2);
    chk("rst_ab_restart", sub_start, 5'b00010);
    sub_done = 5'b00010;
    tick();
    clear_inputs();
    chk("rst_ab_resp_ok", {resp_valid, resp_status}, {1'b1, 2'b00});
    wait_idle("rst_ab", 1'b0);

    // randomized transactions
    for (int t = 0; t < 30; t++) begin
      m      = 3'($urandom_range(0, 7));
      sc     = int'($urandom_range(0, 6));
      d      = int'($urandom_range(0, 15));
      da     = int'($urandom_range(0, 6));
      exp_oh = (m >= 3'd1 && m <= 3'd5) ? (5'd1 << (m - 3'd1)) : 5'd0;
      exp_st = model_status(m, sc);
      request(m);
      chk("rnd_start", sub_start, 32'(exp_oh));
      if (exp_oh != 5'd0) begin
        for (int k = 0; k < d; k++) begin
          sub_done = 5'($urandom) & ~exp_oh;
          sub_err  = 5'($urandom) & ~exp_oh;
          tick();
          chk("rnd_run", {resp_valid, active_mode}, {1'b0, m});
        end
        clear_inputs();
        case (sc)
          0: sub_done = exp_oh;
          1: sub_err = exp_oh;
          5: begin sub_done = exp_oh; exit_pulse = 1'b1; end
          6: begin sub_done = exp_oh; sub_err = exp_oh; end
          default: exit_pulse = 1'b1;
        endcase
        tick();
        clear_inputs();
        if (sc >= 2 && sc <= 4) begin
          chk("rnd_abort", sub_abort, 32'(exp_oh));
          w = (sc == 3) ? 7 : da;
          for (int k = 0; k < w; k++) begin
            tick();
            chk("rnd_abort_hold", {resp_valid, sub_abort}, {1'b0, exp_oh});
          end
          if (sc == 2) sub_done = exp_oh;
          if (sc == 4) sub_err = exp_oh;
          tick();
          clear_inputs();
        end
      end
      chk("rnd_resp_valid", resp_valid, 1);
      chk("rnd_resp_status", resp_status, 32'(exp_st));
      wait_idle("rnd", exp_st != 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
